// File: rtl/srio_single_bus_arb.sv
// Two-port arbiter and cycle sequencer for the SRIO single-register access bus.
// Define SRIO_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module srio_single_bus_arb #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              srio_single_csn,
    output logic              srio_single_rdn,
    output logic              srio_single_wrn,
    output logic [ADDR_W-1:0] srio_single_addr,
    output logic [DATA_W-1:0] srio_single_dout,
    input  logic [DATA_W-1:0] srio_single_din,
    output logic              busy
);

    localparam int unsigned CntMax = (STROBE_CYC > RD_LAT) ? STROBE_CYC : RD_LAT;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax + 1) : 1;

    typedef enum logic [1:0] {StIdle, StStrobe, StHold, StAck} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              gnt_q;
    logic              we_q;
    logic              gnt_d;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef SRIO_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_d = ~req0;
    end
`else
    logic last_grant_q;

    // Tie goes to the port that did not win last time.
    always_comb begin
        if (req0 && req1) begin
            gnt_d = ~last_grant_q;
        end else begin
            gnt_d = ~req0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_grant_q <= 1'b1;
        end else if (state_q == StIdle && (req0 || req1)) begin
            last_grant_q <= gnt_d;
        end
    end
`endif

    always_comb begin
        sel_we    = gnt_d ? we1    : we0;
        sel_addr  = gnt_d ? addr1  : addr0;
        sel_wdata = gnt_d ? wdata1 : wdata0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            gnt_q            <= 1'b0;
            we_q             <= 1'b0;
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            rdata0           <= '0;
            rdata1           <= '0;
            srio_single_csn  <= 1'b1;
            srio_single_rdn  <= 1'b1;
            srio_single_wrn  <= 1'b1;
            srio_single_addr <= '0;
            srio_single_dout <= '0;
            busy             <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        gnt_q            <= gnt_d;
                        we_q             <= sel_we;
                        srio_single_addr <= sel_addr;
                        srio_single_dout <= sel_we ? sel_wdata : '0;
                        srio_single_csn  <= 1'b0;
                        srio_single_rdn  <= sel_we;
                        srio_single_wrn  <= ~sel_we;
                        cnt_q            <= CntW'(STROBE_CYC - 1);
                        busy             <= 1'b1;
                        state_q          <= StStrobe;
                    end
                end
                StStrobe: begin
                    if (cnt_q == '0) begin
                        srio_single_csn <= 1'b1;
                        srio_single_rdn <= 1'b1;
                        srio_single_wrn <= 1'b1;
                        cnt_q           <= CntW'(RD_LAT - 1);
                        state_q         <= StHold;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        if (!we_q) begin
                            if (gnt_q) begin
                                rdata1 <= srio_single_din;
                            end else begin
                                rdata0 <= srio_single_din;
                            end
                        end
                        ack0    <= ~gnt_q;
                        ack1    <= gnt_q;
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StAck: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_srio_single_bus_arb.sv
// Directed bench for srio_single_bus_arb (round-robin build): cycle table on the default
// configuration plus a hand sequence on a STROBE_CYC=1, RD_LAT=3 instance.
module tb_srio_single_bus_arb;

    typedef struct packed {
        logic         rst;
        logic         r0;
        logic         w0;
        logic [7:0]   a0;
        logic [31:0]  d0;
        logic         r1;
        logic         w1;
        logic [7:0]   a1;
        logic [31:0]  d1;
        logic [31:0]  din;
        logic [109:0] exp;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0, din = '0;
    logic        ack0, ack1, csn, rdn, wrn, busy;
    logic [31:0] rdata0, rdata1, dout;
    logic [7:0]  baddr;

    logic        rst_b = 1'b1, req0_b = 1'b0, req1_b = 1'b0;
    logic [31:0] din_b = '0;
    logic        ack0_b, ack1_b, csn_b, rdn_b, wrn_b, busy_b;
    logic [31:0] rdata0_b, rdata1_b, dout_b;
    logic [7:0]  baddr_b;

    logic        cur_w0 = 1'b0, cur_w1 = 1'b0;
    logic [7:0]  cur_a0 = '0, cur_a1 = '0;
    logic [31:0] cur_d0 = '0, cur_d1 = '0;

    always #5 sys_clk = ~sys_clk;

    srio_single_bus_arb #(
        .ADDR_W(8), .DATA_W(32), .STROBE_CYC(2), .RD_LAT(1)
    ) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .srio_single_csn(csn), .srio_single_rdn(rdn), .srio_single_wrn(wrn),
        .srio_single_addr(baddr), .srio_single_dout(dout), .srio_single_din(din),
        .busy(busy)
    );

    srio_single_bus_arb #(
        .ADDR_W(8), .DATA_W(32), .STROBE_CYC(1), .RD_LAT(3)
    ) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(rst_b),
        .req0(req0_b), .we0(1'b0), .addr0(8'h05), .wdata0(32'h0), .ack0(ack0_b),
        .rdata0(rdata0_b),
        .req1(req1_b), .we1(1'b0), .addr1(8'h00), .wdata1(32'h0), .ack1(ack1_b),
        .rdata1(rdata1_b),
        .srio_single_csn(csn_b), .srio_single_rdn(rdn_b), .srio_single_wrn(wrn_b),
        .srio_single_addr(baddr_b), .srio_single_dout(dout_b), .srio_single_din(din_b),
        .busy(busy_b)
    );

    task automatic p0(input logic w, input logic [7:0] a, input logic [31:0] d);
        cur_w0 = w; cur_a0 = a; cur_d0 = d;
    endtask

    task automatic p1(input logic w, input logic [7:0] a, input logic [31:0] d);
        cur_w1 = w; cur_a1 = a; cur_d1 = d;
    endtask

    // strb = {csn, rdn, wrn}, ack = {ack1, ack0}
    task automatic v(input logic rst, input logic r0, input logic r1, input logic [31:0] dn,
                     input logic [2:0] strb, input logic [7:0] a, input logic [31:0] dout_e,
                     input logic [1:0] ack, input logic [31:0] rd0, input logic [31:0] rd1,
                     input logic bsy);
        vec_t t;
        t.rst = rst; t.r0 = r0; t.w0 = cur_w0; t.a0 = cur_a0; t.d0 = cur_d0;
        t.r1 = r1; t.w1 = cur_w1; t.a1 = cur_a1; t.d1 = cur_d1; t.din = dn;
        t.exp = {strb, a, dout_e, ack, rd0, rd1, bsy};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] D1 = 32'h1234_5678;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] WD = 32'hA5A5_0001;
    localparam logic [31:0] D2 = 32'hCAFE_F00D;
    localparam logic [31:0] D3 = 32'h0BAD_C0DE;
    localparam logic [31:0] D4 = 32'h1111_2222;
    localparam logic [31:0] D5 = 32'h3333_4444;
    localparam logic [31:0] D6 = 32'h7777_8888;

    initial begin
        // Port 0 read at 0x08
        p0(1'b0, 8'h08, 32'h0);
        v(1, 0, 0, 32'h0, 3'b111, 8'h00, 32'h0, 2'b00, 32'h0, 32'h0, 0);
        v(0, 1, 0, D1, 3'b001, 8'h08, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 0, D1, 3'b001, 8'h08, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 0, D1, 3'b111, 8'h08, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 0, D1, 3'b111, 8'h08, 32'h0, 2'b01, D1, 32'h0, 1);
        v(0, 0, 0, D1, 3'b111, 8'h08, 32'h0, 2'b00, D1, 32'h0, 0);
        // Port 1 write at 0x04; rdata untouched
        p1(1'b1, 8'h04, WD);
        v(0, 0, 1, DB, 3'b010, 8'h04, WD, 2'b00, D1, 32'h0, 1);
        v(0, 0, 1, DB, 3'b010, 8'h04, WD, 2'b00, D1, 32'h0, 1);
        v(0, 0, 1, DB, 3'b111, 8'h04, WD, 2'b00, D1, 32'h0, 1);
        v(0, 0, 1, DB, 3'b111, 8'h04, WD, 2'b10, D1, 32'h0, 1);
        v(0, 0, 0, DB, 3'b111, 8'h04, WD, 2'b00, D1, 32'h0, 0);
        // Tie right after reset: port 0 then port 1
        v(1, 0, 0, 32'h0, 3'b111, 8'h00, 32'h0, 2'b00, 32'h0, 32'h0, 0);
        p0(1'b0, 8'h10, 32'h0);
        p1(1'b0, 8'h20, 32'h0);
        v(0, 1, 1, D2, 3'b001, 8'h10, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 1, D2, 3'b001, 8'h10, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 1, D2, 3'b111, 8'h10, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 1, D2, 3'b111, 8'h10, 32'h0, 2'b01, D2, 32'h0, 1);
        v(0, 0, 1, D2, 3'b111, 8'h10, 32'h0, 2'b00, D2, 32'h0, 0);
        v(0, 0, 1, D2, 3'b001, 8'h20, 32'h0, 2'b00, D2, 32'h0, 1);
        v(0, 0, 1, D2, 3'b001, 8'h20, 32'h0, 2'b00, D2, 32'h0, 1);
        v(0, 0, 1, D3, 3'b111, 8'h20, 32'h0, 2'b00, D2, 32'h0, 1);
        v(0, 0, 1, D3, 3'b111, 8'h20, 32'h0, 2'b10, D2, D3, 1);
        v(0, 0, 0, D3, 3'b111, 8'h20, 32'h0, 2'b00, D2, D3, 0);
        // Port 0 alone, port 1 joins mid-transaction, port 0 keeps requesting
        p0(1'b0, 8'h30, 32'h0);
        p1(1'b0, 8'h40, 32'h0);
        v(0, 1, 0, D4, 3'b001, 8'h30, 32'h0, 2'b00, D2, D3, 1);
        v(0, 1, 1, D4, 3'b001, 8'h30, 32'h0, 2'b00, D2, D3, 1);
        v(0, 1, 1, D4, 3'b111, 8'h30, 32'h0, 2'b00, D2, D3, 1);
        v(0, 1, 1, D4, 3'b111, 8'h30, 32'h0, 2'b01, D4, D3, 1);
        v(0, 1, 1, D4, 3'b111, 8'h30, 32'h0, 2'b00, D4, D3, 0);
        v(0, 1, 1, D5, 3'b001, 8'h40, 32'h0, 2'b00, D4, D3, 1);
        v(0, 1, 1, D5, 3'b001, 8'h40, 32'h0, 2'b00, D4, D3, 1);
        v(0, 1, 1, D5, 3'b111, 8'h40, 32'h0, 2'b00, D4, D3, 1);
        v(0, 1, 1, D5, 3'b111, 8'h40, 32'h0, 2'b10, D4, D5, 1);
        v(0, 1, 0, D5, 3'b111, 8'h40, 32'h0, 2'b00, D4, D5, 0);
        v(0, 1, 0, D5, 3'b001, 8'h30, 32'h0, 2'b00, D4, D5, 1);
        v(0, 1, 0, D5, 3'b001, 8'h30, 32'h0, 2'b00, D4, D5, 1);
        // Reset in the second strobe cycle, then the read is re-requested
        v(1, 1, 0, D5, 3'b111, 8'h00, 32'h0, 2'b00, 32'h0, 32'h0, 0);
        v(0, 1, 0, D6, 3'b001, 8'h30, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 0, D6, 3'b001, 8'h30, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 0, D6, 3'b111, 8'h30, 32'h0, 2'b00, 32'h0, 32'h0, 1);
        v(0, 1, 0, D6, 3'b111, 8'h30, 32'h0, 2'b01, D6, 32'h0, 1);
        v(0, 0, 0, D6, 3'b111, 8'h30, 32'h0, 2'b00, D6, 32'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            sys_rst = vecs[i].rst;
            req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
            req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
            din = vecs[i].din;
            @(posedge sys_clk);
            #1;
            chk($sformatf("vec%0d", i),
                128'({csn, rdn, wrn, baddr, dout, ack1, ack0, rdata0, rdata1, busy}),
                128'(vecs[i].exp));
        end

        // STROBE_CYC=1, RD_LAT=3 read on the second instance
        rst_b = 1'b1;
        @(posedge sys_clk); #1;
        chk("b_reset", 128'({csn_b, rdn_b, wrn_b, busy_b, ack0_b, rdata0_b}),
            128'({3'b111, 1'b0, 1'b0, 32'h0}));
        rst_b = 1'b0; req0_b = 1'b1; din_b = 32'hDEAD_0000;
        @(posedge sys_clk); #1;
        chk("b_t1_strobe", 128'({csn_b, rdn_b, wrn_b, baddr_b, busy_b}),
            128'({3'b001, 8'h05, 1'b1}));
        @(posedge sys_clk); #1;
        chk("b_t2_hold", 128'({csn_b, rdn_b, wrn_b, ack0_b, busy_b}),
            128'({3'b111, 1'b0, 1'b1}));
        @(posedge sys_clk); #1;
        chk("b_t3_hold", 128'({csn_b, ack0_b, rdata0_b}), 128'({1'b1, 1'b0, 32'h0}));
        @(posedge sys_clk); #1;
        chk("b_t4_hold", 128'({csn_b, ack0_b, rdata0_b}), 128'({1'b1, 1'b0, 32'h0}));
        din_b = 32'h9ABC_DEF0;
        @(posedge sys_clk); #1;
        chk("b_t5_ack", 128'({ack0_b, ack1_b, rdata0_b, rdata1_b}),
            128'({1'b1, 1'b0, 32'h9ABC_DEF0, 32'h0}));
        req0_b = 1'b0; din_b = 32'h0;
        @(posedge sys_clk); #1;
        chk("b_t6_idle", 128'({ack0_b, busy_b, csn_b, rdata0_b}),
            128'({1'b0, 1'b0, 1'b1, 32'h9ABC_DEF0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
